i2s_in_frame_arbiter: RTL and testbench

Round-robin, frame-granular arbiter that merges the CN per-channel I2S capture byte streams into one AXI-Stream toward the packetizer/transport.
- Sits downstream of the per-channel capture FIFOs, which present 8-bit beats with tlast at frame end, already moved into the clk domain.
- Once granted, a channel keeps the output until its tlast beat. Frames from different channels never interleave.
- Each output frame is tagged with its source channel (tid) and destination FPGA index (tdest).

---
 rtl/i2s_in_frame_arbiter_pkg.sv | 26 ++
 rtl/i2s_rr_picker.sv | 33 +++
 rtl/i2s_in_frame_arbiter.sv | 174 +++++++++++++++++
 tb/tb_i2s_in_frame_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_in_frame_arbiter_pkg.sv
// rtl/i2s_in_frame_arbiter_pkg.sv - shared constants, FSM encoding and width helpers for the I2S frame arbiter
// Purpose: DST_W/BYTE_W widths, ARB_IDLE/ARB_XFER state encoding, clog2 and
//          id_width (channel-id width, never below 1 bit).
// Ports:   none (package).
package i2s_in_frame_arbiter_pkg;

    localparam int DST_W  = 4;
    localparam int BYTE_W = 8;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_XFER = 1'b1
    } arb_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int id_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/i2s_rr_picker.sv
// rtl/i2s_rr_picker.sv - combinational rotated priority encoder for round-robin grant
// Purpose: returns the first set bit of req at or after ptr, wrapping CN-1 -> 0.
// Ports:   req   [CN]  request vector
//          ptr   [IDW] search start index (always < CN)
//          grant [IDW] selected index (0 when any = 0)
//          any         at least one request present
module i2s_rr_picker
    import i2s_in_frame_arbiter_pkg::*;
#(
    parameter int CN  = 16,
    parameter int IDW = id_width(CN)
) (
    input  logic [CN-1:0]  req,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] grant,
    output logic           any
);

    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        any   = 1'b0;
        for (int i = 0; i < CN; i++) begin
            idx = (int'(ptr) + i) % CN;
            if (!any && req[idx]) begin
                any   = 1'b1;
                grant = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/i2s_in_frame_arbiter.sv
// rtl/i2s_in_frame_arbiter.sv - frame-granular round-robin merge of CN I2S byte streams into one stream
// Purpose: grants one channel per frame (held until its tlast beat), forwards its
//          beats through a single output register stage tagged with tid/tdest.
// Optional: I2S_ARB_TIMEOUT_EN adds a stall counter that closes a stuck frame with
//          a forced beat (tdata 0, tlast 1, tuser 1) after TIMEOUT_CYCLES idle cycles.
// Ports:   clk, arst_n (async active-low)
//          s_axis_tvalid/tready/tlast [CN], s_axis_tdata [8*CN]  per-channel inputs
//          i_enable [CN], i_dst_fpga_index [4*CN]                 per-channel config
//          m_axis_tvalid/tready/tdata/tlast/tid/tdest/tuser       merged output
//          o_busy                                                  high in XFER
module i2s_in_frame_arbiter
    import i2s_in_frame_arbiter_pkg::*;
#(
    parameter int CN             = 16,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int IDW           = id_width(CN)
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic [CN-1:0]        s_axis_tvalid,
    output logic [CN-1:0]        s_axis_tready,
    input  logic [BYTE_W*CN-1:0] s_axis_tdata,
    input  logic [CN-1:0]        s_axis_tlast,
    input  logic [CN-1:0]        i_enable,
    input  logic [DST_W*CN-1:0]  i_dst_fpga_index,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [BYTE_W-1:0]    m_axis_tdata,
    output logic                 m_axis_tlast,
    output logic [IDW-1:0]       m_axis_tid,
    output logic [DST_W-1:0]     m_axis_tdest,
    output logic                 m_axis_tuser,
    output logic                 o_busy
);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   gnt;
    logic [DST_W-1:0] gnt_dest;
    logic [IDW-1:0]   pick;
    logic             pick_any;
    logic [IDW-1:0]   ptr_after;
    logic             out_free;
    logic             accept;
    logic             grant_now;
    logic             frame_end;
    logic             force_beat;
    logic             to_hit;

    i2s_rr_picker #(
        .CN  (CN),
        .IDW (IDW)
    ) u_picker (
        .req   (s_axis_tvalid & i_enable),
        .ptr   (rr_ptr),
        .grant (pick),
        .any   (pick_any)
    );

    // Output register can take a new beat when empty or being drained this cycle.
    assign out_free  = ~m_axis_tvalid | m_axis_tready;
    assign ptr_after = (gnt == IDW'(CN - 1)) ? '0 : gnt + IDW'(1);
    assign o_busy    = (state == ARB_XFER);

`ifdef I2S_ARB_TIMEOUT_EN
    localparam int TW = clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_cnt;
    logic          tuser_q;

    // Counts only idle input cycles of the granted channel; saturates at the limit
    // so to_hit stays asserted until the forced beat fits in the output register.
    assign to_hit = (state == ARB_XFER) && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            to_cnt <= '0;
        end else if (state != ARB_XFER || accept || force_beat) begin
            to_cnt <= '0;
        end else if (!s_axis_tvalid[gnt] && !to_hit) begin
            to_cnt <= to_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            tuser_q <= 1'b0;
        end else if (accept) begin
            tuser_q <= 1'b0;
        end else if (force_beat) begin
            tuser_q <= 1'b1;
        end
    end

    assign m_axis_tuser = tuser_q;
`else
    assign to_hit       = 1'b0;
    assign m_axis_tuser = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        s_axis_tready = '0;
        accept        = 1'b0;
        grant_now     = 1'b0;
        frame_end     = 1'b0;
        force_beat    = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_now = 1'b1;
                    state_nxt = ARB_XFER;
                end
            end
            ARB_XFER: begin
                if (to_hit) begin
                    if (out_free) begin
                        force_beat = 1'b1;
                        frame_end  = 1'b1;
                        state_nxt  = ARB_IDLE;
                    end
                end else begin
                    s_axis_tready[gnt] = out_free;
                    accept             = out_free & s_axis_tvalid[gnt];
                    if (accept && s_axis_tlast[gnt]) begin
                        frame_end = 1'b1;
                        state_nxt = ARB_IDLE;
                    end
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state         <= ARB_IDLE;
            rr_ptr        <= '0;
            gnt           <= '0;
            gnt_dest      <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tid    <= '0;
            m_axis_tdest  <= '0;
        end else begin
            state <= state_nxt;
            if (grant_now) begin
                gnt      <= pick;
                gnt_dest <= i_dst_fpga_index[DST_W*int'(pick) +: DST_W];
            end
            if (frame_end) begin
                rr_ptr <= ptr_after;
            end
            if (accept) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= s_axis_tdata[BYTE_W*int'(gnt) +: BYTE_W];
                m_axis_tlast  <= s_axis_tlast[gnt];
                m_axis_tid    <= gnt;
                m_axis_tdest  <= gnt_dest;
            end else if (force_beat) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= '0;
                m_axis_tlast  <= 1'b1;
                m_axis_tid    <= gnt;
                m_axis_tdest  <= gnt_dest;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_in_frame_arbiter.sv
// tb/tb_i2s_in_frame_arbiter.sv - randomized self-checking bench for i2s_in_frame_arbiter
// Purpose: queue-based upstream sources, a frame-level round-robin reference model
//          and an expected-beat scoreboard checked on every output handshake.
module tb_i2s_in_frame_arbiter;

    localparam int CN  = 16;
    localparam int IDW = 4;

    typedef struct {
        logic [7:0]     data;
        logic           last;
        logic [IDW-1:0] tid;
        logic [3:0]     dest;
    } beat_t;

    logic              clk;
    logic              arst_n;
    logic [CN-1:0]     s_axis_tvalid;
    logic [CN-1:0]     s_axis_tready;
    logic [8*CN-1:0]   s_axis_tdata;
    logic [CN-1:0]     s_axis_tlast;
    logic [CN-1:0]     i_enable;
    logic [4*CN-1:0]   i_dst_fpga_index;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [7:0]        m_axis_tdata;
    logic              m_axis_tlast;
    logic [IDW-1:0]    m_axis_tid;
    logic [3:0]        m_axis_tdest;
    logic              m_axis_tuser;
    logic              o_busy;

    i2s_in_frame_arbiter #(
        .CN             (CN),
        .TIMEOUT_CYCLES (256)
    ) dut (
        .clk              (clk),
        .arst_n           (arst_n),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tlast     (s_axis_tlast),
        .i_enable         (i_enable),
        .i_dst_fpga_index (i_dst_fpga_index),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tid       (m_axis_tid),
        .m_axis_tdest     (m_axis_tdest),
        .m_axis_tuser     (m_axis_tuser),
        .o_busy           (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // upstream FIFO contents and reference-model frame lists
    logic [7:0] src_data [CN][$];
    bit         src_last [CN][$];
    logic [7:0] mdl_bytes[CN][$];
    int         mdl_lens [CN][$];
    beat_t      exp_q[$];
    int         dst[CN];
    int         mdl_ptr = 0;

    bit [CN-1:0] hs;
    bit [CN-1:0] mid;
    bit [CN-1:0] en_next;
    bit rand_mode = 0;
    bit tog_mode  = 0;
    bit lat_arm   = 0;
    bit lat_watch = 0;
    int v_cyc     = 0;
    int lat_cyc   = 0;
    bit lat_busy  = 0;
    int beats_seen = 0;
    bit dis_active   = 0;
    bit dis_rdy_seen = 0;
    bit multi_rdy    = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input int ch, input int len, input int base);
        logic [7:0] b;
        for (int i = 0; i < len; i++) begin
            b = (base < 0) ? 8'($urandom_range(0, 255)) : 8'(base + i);
            src_data[ch].push_back(b);
            src_last[ch].push_back(i == len - 1);
            mdl_bytes[ch].push_back(b);
        end
        mdl_lens[ch].push_back(len);
    endtask

    // Frame-level round robin: first enabled channel with a pending frame at or
    // after the pointer wins the whole frame; pointer moves past the winner.
    task automatic plan();
        bit    found;
        int    pick;
        int    c;
        int    len;
        beat_t e;
        while (1) begin
            found = 0;
            pick  = 0;
            for (int k = 0; k < CN; k++) begin
                c = (mdl_ptr + k) % CN;
                if (!found && en_next[c] && mdl_lens[c].size() > 0) begin
                    found = 1;
                    pick  = c;
                end
            end
            if (!found) break;
            len = mdl_lens[pick].pop_front();
            for (int i = 0; i < len; i++) begin
                e.data = mdl_bytes[pick].pop_front();
                e.last = (i == len - 1);
                e.tid  = IDW'(pick);
                e.dest = 4'(dst[pick]);
                exp_q.push_back(e);
            end
            mdl_ptr = (pick + 1) % CN;
        end
    endtask

    function automatic int pending_src();
        int n;
        n = 0;
        for (int ch = 0; ch < CN; ch++) if (en_next[ch]) n += src_data[ch].size();
        return n;
    endfunction

    task automatic wait_drain(input string tag);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || pending_src() != 0) && k < 4000) begin
            @(negedge clk);
            k++;
        end
        repeat (6) @(negedge clk);
        check_eq(tag, exp_q.size(), 0);
    endtask

    task automatic wait_beats(input int n, input string tag);
        int k;
        k = 0;
        while (beats_seen < n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, 32'(beats_seen >= n), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_tvalid"}, m_axis_tvalid, 0);
        check_eq({tag, "_tdata"},  m_axis_tdata, 0);
        check_eq({tag, "_tlast"},  m_axis_tlast, 0);
        check_eq({tag, "_tid"},    m_axis_tid, 0);
        check_eq({tag, "_tdest"},  m_axis_tdest, 0);
        check_eq({tag, "_tuser"},  m_axis_tuser, 0);
        check_eq({tag, "_busy"},   o_busy, 0);
        check_eq({tag, "_sready"}, s_axis_tready, 0);
    endtask

    // Upstream sources: valid held until accepted, random gaps only inside a frame.
    initial begin : driver
        logic [8*CN-1:0] d;
        logic [CN-1:0]   v;
        logic [CN-1:0]   l;
        logic [7:0]      dummy_b;
        bit              dummy_l;
        bit              popped;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            d = s_axis_tdata;
            v = s_axis_tvalid;
            l = s_axis_tlast;
            for (int ch = 0; ch < CN; ch++) begin
                popped = hs[ch];
                if (popped && src_data[ch].size() > 0) begin
                    mid[ch] = !src_last[ch][0];
                    dummy_b = src_data[ch].pop_front();
                    dummy_l = src_last[ch].pop_front();
                end
                hs[ch] = 0;
                if (src_data[ch].size() == 0)       v[ch] = 1'b0;
                else if (v[ch] && !popped)          v[ch] = 1'b1;
                else if (mid[ch] && rand_mode)      v[ch] = ($urandom_range(0, 3) != 0);
                else                                v[ch] = 1'b1;
                if (src_data[ch].size() > 0) begin
                    d[8*ch +: 8] = src_data[ch][0];
                    l[ch]        = src_last[ch][0];
                end else begin
                    d[8*ch +: 8] = 8'h00;
                    l[ch]        = 1'b0;
                end
            end
            if (lat_arm && v[3]) begin
                v_cyc   = cyc;
                lat_arm = 0;
            end
            s_axis_tvalid = v;
            s_axis_tdata  = d;
            s_axis_tlast  = l;
            i_enable      = en_next;
            if (tog_mode)       m_axis_tready = ~m_axis_tready;
            else if (rand_mode) m_axis_tready = 1'($urandom_range(0, 1));
            else                m_axis_tready = 1'b1;
        end
    end

    always @(negedge clk) begin : monitor
        beat_t e;
        if (!arst_n) begin
            hs = '0;
        end else begin
            for (int ch = 0; ch < CN; ch++) hs[ch] = s_axis_tvalid[ch] & s_axis_tready[ch];
            if ($countones(s_axis_tready) > 1) multi_rdy = 1;
            if (dis_active && s_axis_tready[2]) dis_rdy_seen = 1;
            if (m_axis_tvalid && m_axis_tready) begin
                beats_seen++;
                if (lat_watch) begin
                    lat_cyc   = cyc;
                    lat_busy  = o_busy;
                    lat_watch = 0;
                end
                if (exp_q.size() == 0) begin
                    check_eq("extra_beat", m_axis_tvalid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("tdata", m_axis_tdata, e.data);
                    check_eq("tlast", m_axis_tlast, e.last);
                    check_eq("tid",   m_axis_tid,   e.tid);
                    check_eq("tdest", m_axis_tdest, e.dest);
                    check_eq("tuser", m_axis_tuser, 0);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base;
        arst_n  = 1'b0;
        en_next = '1;
        i_enable = '1;
        for (int c = 0; c < CN; c++) dst[c] = $urandom_range(0, 15);
        dst[3] = 5;
        for (int c = 0; c < CN; c++) i_dst_fpga_index[4*c +: 4] = 4'(dst[c]);
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        arst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single channel, latency and tagging
        lat_arm   = 1;
        lat_watch = 1;
        push_frame(3, 4, 8'h11);
        plan();
        wait_drain("drain_ch3");
        check_eq("latency", lat_cyc - v_cyc, 2);
        check_eq("busy_xfer", lat_busy, 1);

        // three channels, repeated 2-beat frames
        rand_mode = 1;
        for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) push_frame(c, 2, 8'h20 + 16*c + 2*r);
        plan();
        wait_drain("drain_rr012");

        // channel 2 disabled with data pending, random traffic on the others
        en_next[2] = 0;
        repeat (3) @(negedge clk);
        dis_active = 1;
        push_frame(2, 3, 8'hC0);
        for (int c = 0; c < CN; c++) begin
            if (c != 2) begin
                for (int f = $urandom_range(0, 2); f > 0; f--) push_frame(c, $urandom_range(1, 6), -1);
            end
        end
        push_frame(0, 1, -1);
        push_frame(1, 6, -1);
        plan();
        wait_drain("drain_random");
        dis_active = 0;
        check_eq("disabled_ready", dis_rdy_seen, 0);
        en_next[2] = 1;
        plan();
        wait_drain("drain_ch2_enabled");

        // 6-beat frame under alternating downstream ready
        rand_mode = 0;
        tog_mode  = 1;
        push_frame(11, 6, 8'h61);
        plan();
        wait_drain("drain_toggle");
        tog_mode = 0;

        // enable dropped mid-frame must not truncate the frame
        rand_mode = 1;
        base = beats_seen;
        push_frame(6, 6, 8'h71);
        plan();
        wait_beats(base + 2, "mid_en_beats");
        en_next[6] = 0;
        wait_drain("drain_mid_disable");
        en_next[6] = 1;
        rand_mode  = 0;

        // reset in the middle of a frame, pointer left at 6 beforehand
        push_frame(5, 1, 8'h55);
        plan();
        wait_drain("drain_ch5");
        base = beats_seen;
        push_frame(1, 5, 8'hA1);
        plan();
        wait_beats(base + 3, "pre_reset_beats");
        #2;
        arst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        for (int c = 0; c < CN; c++) begin
            src_data[c].delete();
            src_last[c].delete();
            mdl_bytes[c].delete();
            mdl_lens[c].delete();
        end
        exp_q.delete();
        mid     = '0;
        hs      = '0;
        mdl_ptr = 0;
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        repeat (2) @(negedge clk);
        push_frame(7, 2, 8'hB1);
        push_frame(1, 3, 8'hD1);
        plan();
        wait_drain("drain_post_reset");

        check_eq("one_hot_ready", multi_rdy, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
